// File: rtl/collatz_stepper_if.sv
// collatz_stepper_if: slow-clock, load request and result bundle for collatz_stepper.
// Revision: 1.0
`default_nettype none

interface collatz_stepper_if #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = 8
) ();
  logic                   slow_clk;
  logic                   start;
  logic [WIDTH-1:0]       seed;
  logic [WIDTH-1:0]       value;
  logic [COUNT_WIDTH-1:0] steps;
  logic [WIDTH-1:0]       peak;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    output slow_clk, start, seed,
    input  value, steps, peak, busy, done, overflow
  );

  modport slave (
    input  slow_clk, start, seed,
    output value, steps, peak, busy, done, overflow
  );
endinterface

`default_nettype wire

// File: rtl/collatz_stepper.sv
// collatz_stepper: advances one 3n+1 step per rising edge of the divided slow clock.
// Revision: 1.0
`default_nettype none

module collatz_stepper #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic               clkin,
  input  logic               reset,
  collatz_stepper_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] c_STEPS_MAX = '1;

  logic [1:0]             r_state;
  logic                   r_slow_q;
  logic [WIDTH-1:0]       r_value;
  logic [COUNT_WIDTH-1:0] r_steps;
  logic [WIDTH-1:0]       r_peak;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;

  logic                   w_tick;
  logic [WIDTH+1:0]       w_ext;
  logic [WIDTH+1:0]       w_next;
  logic                   w_fits;
  logic [WIDTH-1:0]       w_next_val;

  assign w_tick     = bus.slow_clk & ~r_slow_q;
  assign w_ext      = {2'b00, r_value};
  // Two guard bits hold the widest 3n+1 so overflow is a simple top-bits test.
  assign w_next     = r_value[0] ? (w_ext + (w_ext << 1) + (WIDTH+2)'(1)) : (w_ext >> 1);
  assign w_fits     = (w_next[WIDTH+1:WIDTH] == 2'b00);
  assign w_next_val = w_next[WIDTH-1:0];

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_slow_q   <= 1'b0;
      r_value    <= '0;
      r_steps    <= '0;
      r_peak     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_slow_q <= bus.slow_clk;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.start && (bus.seed != '0)) begin
            r_value    <= bus.seed;
            r_peak     <= bus.seed;
            r_steps    <= '0;
            r_overflow <= 1'b0;
            if (bus.seed == WIDTH'(1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_HALT;
            end else begin
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_tick) begin
            if (!w_fits) begin
              r_overflow <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_HALT;
            end else begin
              r_value <= w_next_val;
              if (r_steps != c_STEPS_MAX) begin
                r_steps <= r_steps + COUNT_WIDTH'(1);
              end
              if (w_next_val > r_peak) begin
                r_peak <= w_next_val;
              end
              if (w_next_val == WIDTH'(1)) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_HALT;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value    = r_value;
  assign bus.steps    = r_steps;
  assign bus.peak     = r_peak;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_collatz_stepper.sv
// tb_collatz_stepper: random and directed checks of two collatz_stepper instances against a trajectory model.
// Revision: 1.0
`default_nettype none

module tb_collatz_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic        slow;
  logic        start;
  logic [15:0] s16;
  logic [7:0]  s8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  collatz_stepper_if #(.WIDTH(16), .COUNT_WIDTH(8)) b16 ();
  collatz_stepper_if #(.WIDTH(8),  .COUNT_WIDTH(4)) b8  ();

  assign b16.slow_clk = slow;
  assign b16.start    = start;
  assign b16.seed     = s16;
  assign b8.slow_clk  = slow;
  assign b8.start     = start;
  assign b8.seed      = s8;

  collatz_stepper #(.WIDTH(16), .COUNT_WIDTH(8)) u_dut16 (
    .clkin (clk),
    .reset (reset),
    .bus   (b16.slave)
  );

  collatz_stepper #(.WIDTH(8), .COUNT_WIDTH(4)) u_dut8 (
    .clkin (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  typedef struct {
    longint v;
    longint st;
    longint pk;
    bit     busy;
    bit     done;
    bit     ovf;
  } res_t;

  // Outcome of n ticks applied to a freshly loaded seed (seed 0 means "never loaded").
  function automatic res_t model(input int w, input int cw, input longint seed, input int n);
    res_t   r;
    longint nx;
    r.v = 0; r.st = 0; r.pk = 0; r.busy = 0; r.done = 0; r.ovf = 0;
    if (seed == 0) return r;
    r.v  = seed;
    r.pk = seed;
    if (seed == 1) begin
      r.done = 1;
      return r;
    end
    r.busy = 1;
    for (int i = 0; i < n && r.busy; i++) begin
      nx = (r.v % 2 == 0) ? r.v / 2 : 3 * r.v + 1;
      if (nx > (longint'(1) << w) - 1) begin
        r.ovf  = 1;
        r.busy = 0;
      end else begin
        r.v = nx;
        if (r.st < (longint'(1) << cw) - 1) r.st = r.st + 1;
        if (nx > r.pk) r.pk = nx;
        if (nx == 1) begin
          r.done = 1;
          r.busy = 0;
        end
      end
    end
    return r;
  endfunction

  longint cur_seed [2];
  int     nt       [2];
  int     W        [2] = '{16, 8};
  int     CW       [2] = '{8, 4};
  logic   prev_slow;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    res_t m;
    m = model(W[0], CW[0], cur_seed[0], nt[0]);
    check("w16 value", 64'(b16.value), m.v);
    check("w16 steps", 64'(b16.steps), m.st);
    check("w16 peak",  64'(b16.peak),  m.pk);
    check("w16 busy",  64'(b16.busy),  64'(m.busy));
    check("w16 done",  64'(b16.done),  64'(m.done));
    check("w16 ovf",   64'(b16.overflow), 64'(m.ovf));
    m = model(W[1], CW[1], cur_seed[1], nt[1]);
    check("w8 value", 64'(b8.value), m.v);
    check("w8 steps", 64'(b8.steps), m.st);
    check("w8 peak",  64'(b8.peak),  m.pk);
    check("w8 busy",  64'(b8.busy),  64'(m.busy));
    check("w8 done",  64'(b8.done),  64'(m.done));
    check("w8 ovf",   64'(b8.overflow), 64'(m.ovf));
  endtask

  // Update the model's view of what the coming edge does, then clock and compare.
  task automatic cyc();
    res_t   m;
    longint sd;
    for (int d = 0; d < 2; d++) begin
      sd = (d == 0) ? longint'(s16) : longint'(s8);
      m  = model(W[d], CW[d], cur_seed[d], nt[d]);
      if (reset) begin
        cur_seed[d] = 0;
        nt[d]       = 0;
      end else if (start && sd != 0 && !m.busy && !(cur_seed[d] != 0 && !m.done && !m.ovf)) begin
        cur_seed[d] = sd;
        nt[d]       = 0;
      end else if (slow && !prev_slow) begin
        nt[d]++;
      end
    end
    prev_slow = reset ? 1'b0 : slow;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic tick();
    slow = 1'b1;
    cyc();
    slow = 1'b0;
    cyc();
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] b);
    s16   = a;
    s8    = b;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    res_t m;
    reset = 1'b1; slow = 1'b0; start = 1'b0; s16 = '0; s8 = '0; prev_slow = 1'b0;
    cur_seed = '{0, 0};
    nt       = '{0, 0};
    cyc();
    cyc();
    check("reset value", 64'(b16.value), 64'd0);
    reset = 1'b0;
    cyc();

    // seed 6, eight ticks to 1
    load(16'd6, 8'd6);
    repeat (8) tick();
    check("seed6 steps", 64'(b16.steps), 64'd8);
    check("seed6 peak",  64'(b16.peak),  64'd16);
    check("seed6 done",  64'(b16.done),  64'd1);

    // seed 27 on the wide engine; seed 7 on the narrow one saturates its 4-bit count
    load(16'd27, 8'd7);
    for (int i = 0; i < 300; i++) begin
      m = model(16, 8, cur_seed[0], nt[0]);
      if (!m.busy) break;
      tick();
    end
    check("seed27 steps", 64'(b16.steps), 64'd111);
    check("seed27 peak",  64'(b16.peak),  64'd9232);
    check("seed27 value", 64'(b16.value), 64'd1);
    check("seed7 sat steps", 64'(b8.steps), 64'd15);
    repeat (3) tick();
    check("seed27 hold steps", 64'(b16.steps), 64'd111);

    // seed 1 completes immediately; 255 on 8 bits overflows on the first step
    load(16'd1, 8'd255);
    check("seed1 done", 64'(b16.done), 64'd1);
    check("seed1 busy", 64'(b16.busy), 64'd0);
    tick();
    check("ovf8 flag",  64'(b8.overflow), 64'd1);
    check("ovf8 value", 64'(b8.value), 64'd255);
    check("ovf8 steps", 64'(b8.steps), 64'd0);
    load(16'd0, 8'd4);
    check("seed0 keeps halt", 64'(b16.done), 64'd1);
    repeat (2) tick();
    check("reload8 steps", 64'(b8.steps), 64'd2);
    check("reload8 done",  64'(b8.done),  64'd1);
    check("reload8 ovf",   64'(b8.overflow), 64'd0);

    // seed 0 from IDLE is ignored
    do_reset();
    load(16'd0, 8'd0);
    check("seed0 idle busy", 64'(b16.busy), 64'd0);

    // start in RUN ignored; held-high slow clock gives one step
    load(16'd27, 8'd27);
    repeat (2) tick();
    load(16'd9, 8'd9);
    check("run ignore start", 64'(b16.value), 64'd41);
    slow = 1'b1;
    repeat (20) cyc();
    slow = 1'b0;
    cyc();
    check("held high one step", 64'(b16.value), 64'd124);

    // start coincident with a tick loads only
    do_reset();
    slow = 1'b1;
    load(16'd6, 8'd6);
    check("coincident load", 64'(b16.value), 64'd6);
    cyc();
    slow = 1'b0;
    cyc();
    check("coincident no step", 64'(b16.steps), 64'd0);

    // reset mid-run, then ticks do nothing
    load(16'd27, 8'd27);
    repeat (5) tick();
    do_reset();
    check("mid reset value", 64'(b16.value), 64'd0);
    repeat (3) tick();
    check("post reset busy", 64'(b16.busy), 64'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) slow = ~slow;
      start = ($urandom_range(0, 40) == 0);
      s16   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 10)) : 16'($urandom_range(0, 65535));
      s8    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10))  : 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 700) == 0);
      cyc();
    end
    reset = 1'b0;
    start = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/collatz_stepper.md
# collatz_stepper

Sequential Collatz engine that advances one step of the 3n+1 iteration per rising edge of the divided slow clock produced by the clock divider. It sits directly downstream of the divider: the divider's square-wave output enters this block as `slow_clk` and is edge-detected in the fast `clkin` domain. The block owns the current value, step count, running peak and termination flags that feed the display stage.

## Interface
- `WIDTH`, default 16: bit width of seed, value and peak.
- `COUNT_WIDTH`, default 8: bit width of the step counter.

- `clkin`  in  1  system clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `slow_clk`  in  1  divider output, a level square wave already synchronous to `clkin`; only its rising edge is used.
- `start`  in  1  one-cycle load request.
- `seed`  in  WIDTH  starting value, sampled when `start` is accepted.
- `value`  out  WIDTH  current sequence value.
- `steps`  out  COUNT_WIDTH  steps taken since load; saturating.
- `peak`  out  WIDTH  largest value reached since load, seed included.
- `busy`  out  1  high in RUN.
- `done`  out  1  sequence reached 1 normally.
- `overflow`  out  1  3n+1 exceeded 2^WIDTH-1; run aborted.

## Operation
- Edge detect: `slow_q` is a register copy of `slow_clk`. `tick = slow_clk & ~slow_q`. A held-high `slow_clk` gives exactly one tick.
- States: IDLE, RUN, HALT.
- IDLE or HALT, `start`=1:
  - If `seed`==0: request ignored. State and outputs are unchanged.
  - If `seed`==1: load `value`=1, `peak`=1, `steps`=0. Clear `overflow`. Set `done`=1. Go to HALT.
  - If `seed`>=2: load `value`=`peak`=`seed`, `steps`=0. Clear `done` and `overflow`. Go to RUN.
  - Any `tick` in the same cycle is ignored.
- RUN, on `tick`:
  - Even value: next = value>>1.
  - Odd value: next = 3*value+1, computed at WIDTH+2 bits.
  - If next > 2^WIDTH-1: set `overflow`=1 and go to HALT. `value`, `steps` and `peak` are unchanged.
  - Otherwise: `value`=next. `steps` increments, holding at all-ones once reached; saturation is not an error. `peak`=max(`peak`, next). If next==1: set `done`=1 and go to HALT.
- RUN, no `tick`: hold.
- `start` in RUN is ignored.
- HALT: all outputs hold until a valid `start` or `reset`.
- `busy` = (state==RUN). `done` and `overflow` are never both high.

## Timing
- All outputs are registered.
- Reset values: `value`=0, `steps`=0, `peak`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE and `slow_q`=0.
- `reset` has priority over every other input. Asserted mid-run, all registers take their reset values at the next edge.
- `start` accepted at edge N:
  - Loaded `value`/`peak` are visible after N.
  - `busy` is high from N+1 when the seed is >=2.
  - `done` is high from N+1 when the seed is 1.
- `slow_clk` sampled rising at edge T (`slow_clk`=1, `slow_q`=0): the updated `value`, `steps`, `peak` and any `done`/`overflow` are visible after T, in the same cycle that `busy` falls. Step latency is 1 clkin cycle from the tick.
- With the divider at 5000, one step occurs every 10000 `clkin` cycles. Benches drive `slow_clk` directly with short periods.

## Test plan
- `seed`=6, then 8 ticks: values 3,10,5,16,8,4,2,1. End state `steps`=8, `peak`=16, `done`=1, `busy`=0, `overflow`=0.
- `seed`=27 (WIDTH=16), tick until HALT: `steps`=111, `peak`=9232, `value`=1, `done`=1. Further ticks change nothing.
- `seed`=1: `done`=1 and `value`=1 one cycle after `start`. `busy` never rises and `steps`=0.
- WIDTH=8, `seed`=255, one tick: `overflow`=1, `value`=255, `steps`=0, `done`=0. Then `start` with `seed`=4 clears `overflow` and the run ends with `steps`=2 and `done`=1.
- Edge cases:
  - `seed`=0 with `start` leaves the block in IDLE.
  - `start` with `seed`=9 during a RUN is ignored.
  - `slow_clk` held high for 20 cycles gives exactly 1 step.
  - `start` coincident with a tick loads only.
- `seed`=27, 5 ticks, then `reset` for 1 cycle: all outputs are 0 and the state is IDLE. Ticks then have no effect until the next `start`.
